// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator-side master for the word-organised Data_Memory. It accepts one
// byte, halfword or word load/store from the execute stage at a time. Each
// request becomes a memRead and/or memWrite word access. Load data comes back
// sign- or zero-extended. Sub-word stores use read-modify-write.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         store flag, RV32I width/sign encoding
//   req_addr, req_wdata        byte address, store data
//   resp_valid/resp_err        one-cycle completion pulse, error flag
//   resp_rdata                 extended load data (0 for stores/errors)
//   memRead, memWrite          Data_Memory strobes
//   address, writeData         word-aligned address, full write word
//   readData                   word returned by Data_Memory
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | memRead of the addressed word (loads, SB/SH)
// WR    | memWrite of the full or merged word
// RESP  | resp_valid pulse, then back to IDLE
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            memRead,
    output logic            memWrite,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] writeData,
    input  logic [XLEN-1:0] readData
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]      state;
    logic            weReg;
    logic [2:0]      funct3Reg;
    logic [1:0]      laneReg;
    logic [XLEN-1:0] wdataReg;
    logic            accept;
    logic            reqErr;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    // Strobes decode straight from state so an async reset drops them at once.
    assign memRead    = (state == RD);
    assign memWrite   = (state == WR);
    assign resp_valid = (state == RESP);

    always_comb begin
        reqErr = 1'b0;
        case (req_funct3)
            3'b000: reqErr = 1'b0;
            3'b001: reqErr = MISALIGN_CHECK && req_addr[0];
            3'b010: reqErr = MISALIGN_CHECK && (req_addr[1:0] != 2'b00);
            3'b100: reqErr = req_we;
            3'b101: reqErr = req_we || (MISALIGN_CHECK && req_addr[0]);
            default: reqErr = 1'b1;
        endcase
    end

    function automatic logic [XLEN-1:0] extractLoad(input logic [XLEN-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extractLoad = {{(XLEN-8){b[7]}}, b};
            3'b100:  extractLoad = {{(XLEN-8){1'b0}}, b};
            3'b001:  extractLoad = {{(XLEN-16){h[15]}}, h};
            3'b101:  extractLoad = {{(XLEN-16){1'b0}}, h};
            default: extractLoad = word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] mergeStore(input logic [XLEN-1:0] word,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] lane,
                                                   input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] merged;
        merged = word;
        if (f3 == 3'b000)
            merged[{lane, 3'b000} +: 8] = wd[7:0];
        else
            merged[{lane[1], 4'b0000} +: 16] = wd[15:0];
        mergeStore = merged;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            weReg      <= 1'b0;
            funct3Reg  <= 3'b000;
            laneReg    <= 2'b00;
            wdataReg   <= '0;
            address    <= '0;
            writeData  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        weReg     <= req_we;
                        funct3Reg <= req_funct3;
                        laneReg   <= req_addr[1:0];
                        wdataReg  <= req_wdata;
                        if (reqErr) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            address <= {req_addr[XLEN-1:2], 2'b00};
                            if (req_we && (req_funct3 == 3'b010)) begin
                                writeData <= req_wdata;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    // readData is sampled here, at the edge that ends the read.
                    if (weReg) begin
                        writeData <= mergeStore(readData, funct3Reg, laneReg, wdataReg);
                        state     <= WR;
                    end else begin
                        resp_rdata <= extractLoad(readData, funct3Reg, laneReg);
                        state      <= RESP;
                    end
                end
                WR: begin
                    state <= RESP;
                end
                default: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.XLEN(32), .MISALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    assign readData = mem[address[5:2]];
    always @(posedge clk) if (memWrite) mem[address[5:2]] <= writeData;

    int          rdCnt = 0;
    int          wrCnt = 0;
    int          overlapCnt = 0;
    logic [31:0] lastWd = '0;
    logic [31:0] lastWrAddr = '0;
    logic [31:0] lastRdAddr = '0;
    always @(negedge clk) begin
        if (memRead) begin
            rdCnt      <= rdCnt + 1;
            lastRdAddr <= address;
        end
        if (memWrite) begin
            wrCnt      <= wrCnt + 1;
            lastWd     <= writeData;
            lastWrAddr <= address;
        end
        if (memRead && memWrite) overlapCnt <= overlapCnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReq(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int expLat, input logic expErr, input logic [31:0] expData,
                         input int expRd, input int expWr);
        int rd0, wr0, lat, guard;
        guard = 0;
        while (!req_ready && guard < 10) begin
            tick();
            guard++;
        end
        rd0 = rdCnt;
        wr0 = wrCnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tick();
        req_valid = 1'b0;
        chk({tag, " ready_low"}, {31'b0, req_ready}, 32'd0);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, expLat);
        chk({tag, " err"}, {31'b0, resp_err}, {31'b0, expErr});
        chk({tag, " rdata"}, resp_rdata, expData);
        tick();
        chk({tag, " pulse_end"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, " reads"}, rdCnt - rd0, expRd);
        chk({tag, " writes"}, wrCnt - wr0, expWr);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        #1;
        chk("rst ready", {31'b0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst memRead", {31'b0, memRead}, 32'd0);
        chk("rst memWrite", {31'b0, memWrite}, 32'd0);
        chk("rst address", address, 32'd0);
        chk("rst writeData", writeData, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // SW then sub-word loads of 0xAABBCCDD
        doReq("SW 0x0", 1'b1, 3'b010, 32'h0, 32'hAABBCCDD, 2, 1'b0, 32'h0, 0, 1);
        chk("SW 0x0 wdata", lastWd, 32'hAABBCCDD);
        chk("SW 0x0 addr", lastWrAddr, 32'h0);
        doReq("LB 0x1", 1'b0, 3'b000, 32'h1, 32'h0, 2, 1'b0, 32'hFFFFFFCC, 1, 0);
        chk("LB 0x1 addr", lastRdAddr, 32'h0);
        doReq("LBU 0x1", 1'b0, 3'b100, 32'h1, 32'h0, 2, 1'b0, 32'h000000CC, 1, 0);
        doReq("LH 0x2", 1'b0, 3'b001, 32'h2, 32'h0, 2, 1'b0, 32'hFFFFAABB, 1, 0);
        doReq("LHU 0x2", 1'b0, 3'b101, 32'h2, 32'h0, 2, 1'b0, 32'h0000AABB, 1, 0);
        doReq("LB 0x3", 1'b0, 3'b000, 32'h3, 32'h0, 2, 1'b0, 32'hFFFFFFAA, 1, 0);
        doReq("LBU 0x0", 1'b0, 3'b100, 32'h0, 32'h0, 2, 1'b0, 32'h000000DD, 1, 0);
        doReq("LH 0x0", 1'b0, 3'b001, 32'h0, 32'h0, 2, 1'b0, 32'hFFFFCCDD, 1, 0);
        doReq("LW 0x0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 1'b0, 32'hAABBCCDD, 1, 0);

        // Read-modify-write stores
        doReq("SW 0x4", 1'b1, 3'b010, 32'h4, 32'h11223344, 2, 1'b0, 32'h0, 0, 1);
        doReq("SB 0x5", 1'b1, 3'b000, 32'h5, 32'h000000EE, 3, 1'b0, 32'h0, 1, 1);
        chk("SB 0x5 wdata", lastWd, 32'h1122EE44);
        chk("SB 0x5 addr", lastWrAddr, 32'h4);
        doReq("LW 0x4 a", 1'b0, 3'b010, 32'h4, 32'h0, 2, 1'b0, 32'h1122EE44, 1, 0);
        doReq("SW 0x4 b", 1'b1, 3'b010, 32'h4, 32'h11223344, 2, 1'b0, 32'h0, 0, 1);
        doReq("SH 0x6", 1'b1, 3'b001, 32'h6, 32'h00005566, 3, 1'b0, 32'h0, 1, 1);
        chk("SH 0x6 wdata", lastWd, 32'h55663344);
        doReq("LW 0x4 b", 1'b0, 3'b010, 32'h4, 32'h0, 2, 1'b0, 32'h55663344, 1, 0);

        // Error requests: no memory access, response at cycle 1
        doReq("ERR LW 0x6", 1'b0, 3'b010, 32'h6, 32'h0, 1, 1'b1, 32'h0, 0, 0);
        doReq("ERR LH 0x3", 1'b0, 3'b001, 32'h3, 32'h0, 1, 1'b1, 32'h0, 0, 0);
        doReq("ERR f3 011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0, 0);
        doReq("ERR st 100", 1'b1, 3'b100, 32'h0, 32'h12, 1, 1'b1, 32'h0, 0, 0);
        doReq("ERR f3 111", 1'b0, 3'b111, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0, 0);

        // Reset in the WR state of an SB aborts the store
        doReq("SW 0x8", 1'b1, 3'b010, 32'h8, 32'h01020304, 2, 1'b0, 32'h0, 0, 1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h8;
        req_wdata  = 32'h000000FF;
        tick();
        req_valid = 1'b0;
        chk("abort RD", {31'b0, memRead}, 32'd1);
        tick();
        chk("abort WR", {31'b0, memWrite}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort memWrite", {31'b0, memWrite}, 32'd0);
        chk("abort ready", {31'b0, req_ready}, 32'd1);
        chk("abort resp", {31'b0, resp_valid}, 32'd0);
        tick();
        reset = 1'b0;
        chk("abort resp2", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("abort resp3", {31'b0, resp_valid}, 32'd0);
        doReq("LW 0x8", 1'b0, 3'b010, 32'h8, 32'h0, 2, 1'b0, 32'h01020304, 1, 0);

        // Back-to-back LW with req_valid held high
        begin
            int rd0, acc;
            rd0 = rdCnt;
            acc = 0;
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 32'h0;
            for (int k = 1; k <= 9; k++) begin
                if (req_ready) acc++;
                tick();
                chk($sformatf("b2b ready k%0d", k), {31'b0, req_ready}, {31'b0, (k % 3) == 0});
                chk($sformatf("b2b resp k%0d", k), {31'b0, resp_valid}, {31'b0, (k % 3) == 2});
                if ((k % 3) == 2)
                    chk($sformatf("b2b data k%0d", k), resp_rdata, 32'hAABBCCDD);
            end
            req_valid = 1'b0;
            tick();
            chk("b2b accepts", acc, 32'd3);
            chk("b2b reads", rdCnt - rd0, 32'd3);
        end
        chk("no overlap", overlapCnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
